// File: rtl/quad_decoder.sv
// quad_decoder: quadrature (A/B phase) decoder with a wrapping position counter.
// Both phase inputs are synchronized, then a small FSM waits for the synchronizers
// to fill after reset before it tracks Gray-code steps. Each legal step moves the
// count by +1 or -1, records the direction and pulses `step` for one cycle. A step
// where both phases change at once sets the sticky `err` flag.
module quad_decoder #(
    parameter int WIDTH       = 4,  // position counter width; count wraps modulo 2**WIDTH
    parameter int SYNC_STAGES = 2   // synchronizer depth per phase input, 2..4
) (
    input  logic             clk,
    input  logic             reset,    // asynchronous, active-low
    input  logic             qa,
    input  logic             qb,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             step,
    output logic             err
);

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_e;

    // The INIT counter only ever needs to reach SYNC_STAGES-1 (at most 3).
    localparam logic [2:0]       INIT_LAST = 3'(SYNC_STAGES - 1);
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    // Synchronizer chains; bit 0 is the first flop, bit SYNC_STAGES-1 the last.
    logic [SYNC_STAGES-1:0] qa_sync_q;
    logic [SYNC_STAGES-1:0] qb_sync_q;

    // s is the only view of the phases used by the decoder. s_next is the value
    // s will take after the coming edge.
    logic [1:0] s;
    logic [1:0] s_next;

    state_e           state_q,    state_d;
    logic [2:0]       init_cnt_q, init_cnt_d;
    logic [1:0]       prev_q,     prev_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic             up_down_q,  up_down_d;
    logic             step_q,     step_d;
    logic             err_q,      err_d;

    logic is_up;
    logic is_down;
    logic is_illegal;

    assign s      = {qa_sync_q[SYNC_STAGES-1], qb_sync_q[SYNC_STAGES-1]};
    assign s_next = {qa_sync_q[SYNC_STAGES-2], qb_sync_q[SYNC_STAGES-2]};

    // Shift each asynchronous phase input through its synchronizer chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qa_sync_q <= '0;
            qb_sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments give every flop in the chain the
            // value its predecessor held before the edge; blocking would collapse
            // the chain into a single stage.
            qa_sync_q <= {qa_sync_q[SYNC_STAGES-2:0], qa};
            qb_sync_q <= {qb_sync_q[SYNC_STAGES-2:0], qb};
        end
    end

    // Classify the move from the last tracked phase pair to the current one.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case leaves it unassigned and infers a latch.
        is_up   = 1'b0;
        is_down = 1'b0;
        case ({prev_q, s})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_up   = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_down = 1'b1;
            default: ;
        endcase
    end

    // Both phases flipping between two samples cannot be resolved to a direction.
    assign is_illegal = ((prev_q ^ s) == 2'b11);

    // Next-state and datapath: INIT lets the synchronizers fill, TRACK decodes steps.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = prev_q;
        count_d    = count_q;
        up_down_d  = up_down_q;
        step_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_INIT: begin
                // Outputs keep their reset values and clr is ignored here. On the
                // last INIT cycle prev captures the level that s holds from the
                // coming edge on, so the phase level present at reset release is
                // never seen as a step or as an illegal move.
                if (init_cnt_q == INIT_LAST) begin
                    prev_d  = s_next;
                    state_d = ST_TRACK;
                end else begin
                    init_cnt_d = init_cnt_q + 3'd1;
                end
            end

            ST_TRACK: begin
                // The current sample is always consumed, even when clr discards it.
                prev_d = s;
                if (clr) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (is_up) begin
                    count_d   = count_q + ONE;
                    up_down_d = 1'b1;
                    step_d    = 1'b1;
                end else if (is_down) begin
                    count_d   = count_q - ONE;
                    up_down_d = 1'b0;
                    step_d    = 1'b1;
                end else if (is_illegal) begin
                    err_d = 1'b1;
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    // State, previous-phase and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            prev_q     <= 2'b00;
            count_q    <= '0;
            up_down_q  <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= prev_d;
            count_q    <= count_d;
            up_down_q  <= up_down_d;
            step_q     <= step_d;
            err_q      <= err_d;
        end
    end

    assign count   = count_q;
    assign up_down = up_down_q;
    assign step    = step_q;
    assign err     = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed stimulus for quad_decoder (WIDTH=4, SYNC_STAGES=2).
// Each phase change pushes its expected step (count, direction, due cycle) onto a
// scoreboard; a monitor pops and compares whenever the DUT pulses step.
module tb_quad_decoder;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             qa;
    logic             qb;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic             up_down;
    logic             step;
    logic             err;

    quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .reset   (reset),
        .qa      (qa),
        .qb      (qb),
        .clr     (clr),
        .count   (count),
        .up_down (up_down),
        .step    (step),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             ud;
        int               due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_pass = 0;
    int n_total = 0;
    int pulses = 0;
    int base;

    // Bench-side model of the decoder state.
    logic [1:0]       exp_s;
    logic [WIDTH-1:0] exp_cnt;
    logic             exp_ud;
    logic             exp_err;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: every step pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (sb.size() > 0 && cyc > sb[0].due) begin
            check("step_overdue", cyc, sb[0].due);
            void'(sb.pop_front());
        end
        if (step === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                check("step_without_expectation", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                check("step_count", int'(count), int'(mon_e.cnt));
                check("step_up_down", int'(up_down), int'(mon_e.ud));
                check("step_cycle", cyc, mon_e.due);
            end
        end
    end

    function automatic logic [1:0] next_up(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Drive a new phase pair, record the expected outcome, hold it 4 cycles.
    task automatic phase(input logic [1:0] ns);
        exp_t e;
        @(posedge clk); #1;
        {qa, qb} = ns;
        case ({exp_s, ns})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                exp_cnt = exp_cnt + 4'd1;
                exp_ud  = 1'b1;
                e.cnt = exp_cnt; e.ud = 1'b1; e.due = cyc + 1 + SYNC;
                sb.push_back(e);
            end
            4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
                exp_cnt = exp_cnt - 4'd1;
                exp_ud  = 1'b0;
                e.cnt = exp_cnt; e.ud = 1'b0; e.due = cyc + 1 + SYNC;
                sb.push_back(e);
            end
            4'b0011, 4'b1100, 4'b0110, 4'b1001: exp_err = 1'b1;
            default: ;
        endcase
        exp_s = ns;
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        exp_cnt = '0;
        exp_err = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        // Scenario 1: reset held with both phases high, no phantom step on release.
        reset = 1'b0; qa = 1'b1; qb = 1'b1; clr = 1'b0;
        exp_s = 2'b11; exp_cnt = '0; exp_ud = 1'b0; exp_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_count", int'(count), 0);
        check("rst_up_down", int'(up_down), 0);
        check("rst_step", int'(step), 0);
        check("rst_err", int'(err), 0);
        base = pulses;
        @(posedge clk); #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        settle();
        check("s1_count", int'(count), 0);
        check("s1_err", int'(err), 0);
        check("s1_pulses", pulses - base, 0);

        // Re-reset with phases at 00 to start the counting scenarios.
        @(posedge clk); #1 reset = 1'b0; qa = 1'b0; qb = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        exp_s = 2'b00;
        repeat (10) @(posedge clk);

        // Scenario 2: four up steps.
        base = pulses;
        phase(2'b01); phase(2'b11); phase(2'b10); phase(2'b00);
        settle();
        check("s2_count", int'(count), 4);
        check("s2_up_down", int'(up_down), 1);
        check("s2_pulses", pulses - base, 4);

        // Scenario 3: down wrap 0 -> 15, then 16 up steps back to 15.
        pulse_clr();
        settle();
        check("s3_clr_count", int'(count), 0);
        phase(2'b10);
        settle();
        check("s3_down_wrap_count", int'(count), 15);
        check("s3_down_up_down", int'(up_down), 0);
        for (int i = 0; i < 16; i++) phase(next_up(exp_s));
        settle();
        check("s3_up16_count", int'(count), 15);
        check("s3_up16_up_down", int'(up_down), 1);

        // Up wrap 15 -> 0, then arrange s=00 with count=3.
        phase(2'b00);
        settle();
        check("up_wrap_count", int'(count), 0);
        phase(2'b01);
        pulse_clr();
        phase(2'b11); phase(2'b10); phase(2'b00);
        settle();
        check("s4_pre_count", int'(count), 3);
        check("s4_pre_err", int'(err), 0);

        // Scenario 4: illegal 00 -> 11, err sticks, legal steps still count.
        base = pulses;
        phase(2'b11);
        settle();
        check("s4_err", int'(err), 1);
        check("s4_count", int'(count), 3);
        check("s4_pulses", pulses - base, 0);
        phase(2'b10);
        settle();
        check("s4_after_count", int'(count), 4);
        check("s4_err_sticky", int'(err), 1);

        // Scenario 5: clr on the edge that resolves the up step 10 -> 00.
        base = pulses;
        @(posedge clk); #1 {qa, qb} = 2'b00;
        @(posedge clk);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        exp_s = 2'b00; exp_cnt = '0; exp_err = 1'b0;
        @(negedge clk);
        check("s5_count", int'(count), 0);
        check("s5_err", int'(err), 0);
        check("s5_step", int'(step), 0);
        check("s5_up_down_held", int'(up_down), 1);
        repeat (5) @(posedge clk);
        settle();
        check("s5_later_count", int'(count), 0);
        check("s5_pulses", pulses - base, 0);

        // Scenario 6: count to 7, then asynchronous reset mid-cycle.
        phase(2'b01); phase(2'b11); phase(2'b10); phase(2'b00);
        phase(2'b01); phase(2'b11); phase(2'b10);
        settle();
        check("s6_pre_count", int'(count), 7);
        @(posedge clk); #3 reset = 1'b0;
        #1;
        check("s6_async_count", int'(count), 0);
        check("s6_async_err", int'(err), 0);
        check("s6_async_step", int'(step), 0);
        check("s6_async_up_down", int'(up_down), 0);
        qa = 1'b1; qb = 1'b1;
        exp_s = 2'b11; exp_cnt = '0; exp_ud = 1'b0; exp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        base = pulses;
        repeat (10) @(posedge clk);
        settle();
        check("s6_release_count", int'(count), 0);
        check("s6_release_err", int'(err), 0);
        check("s6_release_pulses", pulses - base, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
